// File: rtl/ecc_pkg.sv
// Shared encodings for the ECC operation sequencer: ops, width codes, FSM
// states, and the codeword/data-bit lookup and mask helpers.
package ecc_pkg;

  localparam int ECC_AMBA_WORD  = 32;
  localparam int ECC_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_ENC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_FULL = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  localparam logic [1:0] WIDTH_8  = 2'b00;
  localparam logic [1:0] WIDTH_16 = 2'b01;
  localparam logic [1:0] WIDTH_32 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ENC  = 2'b01,
    ST_DEC  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Width code 11 behaves exactly like the 32-bit code.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'b11) ? WIDTH_32 : w;
  endfunction

  function automatic logic [6:0] cw_bits(input logic [1:0] w);
    logic [6:0] n;
    case (w)
      WIDTH_8:  n = 7'd8;
      WIDTH_16: n = 7'd16;
      default:  n = 7'd32;
    endcase
    return n;
  endfunction

  function automatic logic [6:0] data_bits(input logic [1:0] w);
    logic [6:0] n;
    case (w)
      WIDTH_8:  n = 7'd4;
      WIDTH_16: n = 7'd11;
      default:  n = 7'd26;
    endcase
    return n;
  endfunction

  function automatic logic [ECC_AMBA_WORD-1:0] mask_bits(input logic [6:0] n);
    logic [ECC_AMBA_WORD-1:0] m;
    m = '0;
    for (int i = 0; i < ECC_AMBA_WORD; i++) begin
      m[i] = (7'(i) < n);
    end
    return m;
  endfunction

  function automatic logic [ECC_AMBA_WORD-1:0] cw_mask(input logic [1:0] w);
    return mask_bits(cw_bits(w));
  endfunction

  function automatic logic [ECC_AMBA_WORD-1:0] data_mask(input logic [1:0] w);
    return mask_bits(data_bits(w));
  endfunction

endpackage

// File: rtl/ecc_seq_stats.sv
// Saturating operation/error/drop counters for the ECC sequencer.
// Present only when ECC_SEQ_STATS_EN is defined.
`ifdef ECC_SEQ_STATS_EN
module ecc_seq_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        stat_clr,
  input  logic        inc_op,
  input  logic        inc_single,
  input  logic        inc_double,
  input  logic        inc_drop,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_single,
  output logic [15:0] stat_double,
  output logic [7:0]  stat_drop
);

  logic [15:0] ops_r;
  logic [15:0] single_r;
  logic [15:0] double_r;
  logic [7:0]  drop_r;

  // Counters saturate at all-ones; clear has priority over any increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_r    <= 16'd0;
      single_r <= 16'd0;
      double_r <= 16'd0;
      drop_r   <= 8'd0;
    end else if (stat_clr) begin
      ops_r    <= 16'd0;
      single_r <= 16'd0;
      double_r <= 16'd0;
      drop_r   <= 8'd0;
    end else begin
      if (inc_op && (ops_r != 16'hFFFF))       ops_r    <= ops_r + 16'd1;
      if (inc_single && (single_r != 16'hFFFF)) single_r <= single_r + 16'd1;
      if (inc_double && (double_r != 16'hFFFF)) double_r <= double_r + 16'd1;
      if (inc_drop && (drop_r != 8'hFF))        drop_r   <= drop_r + 8'd1;
    end
  end

  assign stat_ops    = ops_r;
  assign stat_single = single_r;
  assign stat_double = double_r;
  assign stat_drop   = drop_r;

endmodule
`endif

// File: rtl/ecc_op_sequencer.sv
// Sequences encode / decode / full-channel operations through an external
// ECC encoder/decoder pair. Optional counters under ECC_SEQ_STATS_EN.
module ecc_op_sequencer
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD  = ECC_AMBA_WORD,
  parameter int DATA_WIDTH = ECC_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            ctrl,
  input  logic [1:0]            codeword_width,
  input  logic [AMBA_WORD-1:0]  data_in,
  input  logic [AMBA_WORD-1:0]  noise,
  output logic [1:0]            enc_width,
  output logic [AMBA_WORD-1:0]  enc_data,
  input  logic [DATA_WIDTH-1:0] enc_result,
  output logic [1:0]            dec_width,
  output logic [DATA_WIDTH-1:0] dec_data,
  input  logic [AMBA_WORD-1:0]  dec_result,
  input  logic [1:0]            dec_num_err,
  output logic                  busy,
  output logic                  operation_done,
  output logic [AMBA_WORD-1:0]  data_out,
`ifdef ECC_SEQ_STATS_EN
  input  logic                  stat_clr,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_single,
  output logic [15:0]           stat_double,
  output logic [7:0]            stat_drop,
`endif
  output logic [1:0]            num_of_errors
);

  state_e                  state_r, state_nxt_s;
  op_e                     op_r;
  logic [1:0]              width_r;
  logic [AMBA_WORD-1:0]    data_r;
  logic [AMBA_WORD-1:0]    noise_r;
  logic [DATA_WIDTH-1:0]   dec_data_r;
  logic [AMBA_WORD-1:0]    data_out_r;
  logic [1:0]              num_err_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    accept_s;
  logic [AMBA_WORD-1:0]    res_data_s;
  logic [1:0]              res_err_s;

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE))
                    && (ctrl != OP_ILL);

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_nxt_s = (ctrl == OP_DEC) ? ST_DEC : ST_ENC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ENC: begin
        if (op_r == OP_FULL) begin
          state_nxt_s = ST_DEC;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DEC:  state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Result selection for the transition into DONE.
  always_comb begin
    res_data_s = '0;
    res_err_s  = 2'b00;
    if (state_r == ST_ENC) begin
      res_data_s = AMBA_WORD'(enc_result) & AMBA_WORD'(cw_mask(width_r));
      res_err_s  = 2'b00;
    end else begin
      res_data_s = dec_result & AMBA_WORD'(data_mask(width_r));
      res_err_s  = dec_num_err;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Operand latch, loaded only by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r    <= OP_ENC;
      width_r <= 2'b00;
      data_r  <= '0;
      noise_r <= '0;
    end else if (accept_s) begin
      op_r    <= op_e'(ctrl);
      width_r <= norm_width(codeword_width);
      data_r  <= data_in;
      noise_r <= noise;
    end
  end

  // Decoder input: the masked operand for decode, the noisy codeword for full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_data_r <= '0;
    end else if (accept_s && (ctrl == OP_DEC)) begin
      dec_data_r <= DATA_WIDTH'(data_in & AMBA_WORD'(cw_mask(norm_width(codeword_width))));
    end else if ((state_r == ST_ENC) && (op_r == OP_FULL)) begin
      dec_data_r <= DATA_WIDTH'((AMBA_WORD'(enc_result) ^ noise_r)
                                & AMBA_WORD'(cw_mask(width_r)));
    end
  end

  // Status flags and result register; the result holds until the next DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      data_out_r <= '0;
      num_err_r  <= 2'b00;
    end else begin
      busy_r <= (state_nxt_s == ST_ENC) || (state_nxt_s == ST_DEC);
      done_r <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_DONE) begin
        data_out_r <= res_data_s;
        num_err_r  <= res_err_s;
      end
    end
  end

  assign enc_width      = width_r;
  assign enc_data       = data_r;
  assign dec_width      = width_r;
  assign dec_data       = dec_data_r;
  assign busy           = busy_r;
  assign operation_done = done_r;
  assign data_out       = data_out_r;
  assign num_of_errors  = num_err_r;

`ifdef ECC_SEQ_STATS_EN
  logic fin_dec_s;
  assign fin_dec_s = (state_r == ST_DEC) && (state_nxt_s == ST_DONE);

  ecc_seq_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .stat_clr   (stat_clr),
    .inc_op     (state_nxt_s == ST_DONE),
    .inc_single (fin_dec_s && (dec_num_err == 2'b01)),
    .inc_double (fin_dec_s && (dec_num_err == 2'b10)),
    .inc_drop   (start && !accept_s),
    .stat_ops   (stat_ops),
    .stat_single(stat_single),
    .stat_double(stat_double),
    .stat_drop  (stat_drop)
  );
`endif

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Self-checking bench for ecc_op_sequencer with behavioural extended-Hamming
// encoder/decoder stubs whose unused upper bits are deliberately dirty.
module tb_ecc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  ctrl = 2'b00;
  logic [1:0]  codeword_width = 2'b00;
  logic [31:0] data_in = 32'h0;
  logic [31:0] noise = 32'h0;
  logic [1:0]  enc_width;
  logic [31:0] enc_data;
  logic [31:0] enc_result;
  logic [1:0]  dec_width;
  logic [31:0] dec_data;
  logic [31:0] dec_result;
  logic [31:0] dec_clean;
  logic [1:0]  dec_num_err;
  logic        busy;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
`ifdef ECC_SEQ_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_ops, stat_single, stat_double;
  logic [7:0]  stat_drop;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int tb_cw(input logic [1:0] w);
    return (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
  endfunction

  function automatic int tb_db(input logic [1:0] w);
    return (w == 2'b00) ? 4 : (w == 2'b01) ? 11 : 26;
  endfunction

  function automatic logic [31:0] tb_mask(input int n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << n) - 32'h1;
  endfunction

  // Extended Hamming: positions 1..n-1 with parity at powers of two, overall parity at bit n-1.
  function automatic logic [31:0] ham_enc(input logic [1:0] w, input logic [31:0] d);
    int n = tb_cw(w);
    int j = 0;
    logic [31:0] c = 32'h0;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        j++;
      end
    end
    for (int p = 1; p < n; p = p * 2) begin
      logic b = 1'b0;
      for (int pos = 1; pos < n; pos++) if ((pos & p) != 0) b ^= c[pos-1];
      c[p-1] = b;
    end
    c[n-1] = ^c;
    return c;
  endfunction

  function automatic logic [33:0] ham_dec(input logic [1:0] w, input logic [31:0] c);
    int n = tb_cw(w);
    int syn = 0;
    int j = 0;
    logic ovr;
    logic [31:0] cc = c;
    logic [31:0] d = 32'h0;
    logic [1:0] e;
    for (int pos = 1; pos < n; pos++) if (cc[pos-1]) syn ^= pos;
    ovr = ^cc;
    if (syn == 0 && !ovr) e = 2'b00;
    else if (ovr) begin
      e = 2'b01;
      if (syn != 0) cc[syn-1] = ~cc[syn-1];
    end else e = 2'b10;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = cc[pos-1];
        j++;
      end
    end
    return {e, d};
  endfunction

  assign enc_result = ham_enc(enc_width, enc_data) | ~tb_mask(tb_cw(enc_width));
  assign {dec_num_err, dec_clean} = ham_dec(dec_width, dec_data);
  assign dec_result = dec_clean | ~tb_mask(tb_db(dec_width));

  ecc_op_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl),
    .codeword_width(codeword_width), .data_in(data_in), .noise(noise),
    .enc_width(enc_width), .enc_data(enc_data), .enc_result(enc_result),
    .dec_width(dec_width), .dec_data(dec_data), .dec_result(dec_result),
    .dec_num_err(dec_num_err), .busy(busy), .operation_done(operation_done),
    .data_out(data_out),
`ifdef ECC_SEQ_STATS_EN
    .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_single(stat_single),
    .stat_double(stat_double), .stat_drop(stat_drop),
`endif
    .num_of_errors(num_of_errors)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d,
                        input logic [31:0] nz, output int lat);
    @(negedge clk);
    ctrl = c; codeword_width = w; data_in = d; noise = nz; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!operation_done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full op with a start offered in both busy cycles (both must be dropped).
  task automatic full_with_drops();
    @(negedge clk);
    ctrl = 2'b10; codeword_width = 2'b10; data_in = 32'h0123_4567; noise = 32'h0; start = 1'b1;
    @(negedge clk);
    check("drops_busy_enc", {31'h0, busy}, 32'h1);
    ctrl = 2'b00; data_in = 32'h0;
    @(negedge clk);
    check("drops_busy_dec", {31'h0, busy}, 32'h1);
    @(negedge clk);
    start = 1'b0;
    check("drops_done", {31'h0, operation_done}, 32'h1);
    check("drops_data", data_out, 32'h0123_4567);
    check("drops_latch", enc_data, 32'h0123_4567);
    @(negedge clk);
    check("drops_idle", {31'h0, operation_done | busy}, 32'h0);
  endtask

  task automatic illegal_start();
    logic seen = 1'b0;
    @(negedge clk);
    ctrl = 2'b11; codeword_width = 2'b00; data_in = 32'h5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (operation_done || busy) seen = 1'b1;
      @(negedge clk);
    end
    check("illegal_no_done", {31'h0, seen}, 32'h0);
  endtask

  typedef struct {
    logic [1:0]  c;
    logic [1:0]  w;
    logic [31:0] d;
    logic [31:0] nz;
    logic [31:0] exp_out;
    logic [1:0]  exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 32'h0);
    check("rst_num_err", {30'h0, num_of_errors}, 32'h0);
    check("rst_done", {31'h0, operation_done}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_enc_data", enc_data, 32'h0);
    check("rst_dec_data", dec_data, 32'h0);
    rst = 1'b1;

    vecs[0]  = '{2'b00, 2'b00, 32'h5,         32'h0,         32'h2D,        2'b00, 2};
    vecs[1]  = '{2'b10, 2'b10, 32'h02AB_CDEF, 32'h1,         32'h02AB_CDEF, 2'b01, 3};
    vecs[2]  = '{2'b10, 2'b01, 32'h7FF,       32'h3,         32'h7FF,       2'b10, 3};
    vecs[3]  = '{2'b01, 2'b00, 32'h2D,        32'h0,         32'h5,         2'b00, 2};
    vecs[4]  = '{2'b01, 2'b00, 32'h3D,        32'h0,         32'h5,         2'b01, 2};
    vecs[5]  = '{2'b01, 2'b00, 32'h2E,        32'h0,         32'h5,         2'b10, 2};
    vecs[6]  = '{2'b10, 2'b00, 32'hA,         32'h100,       32'hA,         2'b00, 3};
    vecs[7]  = '{2'b00, 2'b11, 32'h3,         32'h0,         ham_enc(2'b10, 32'h3),   2'b00, 2};
    vecs[8]  = '{2'b00, 2'b01, 32'hFFFF_F923, 32'h0,         ham_enc(2'b01, 32'h123), 2'b00, 2};
    vecs[9]  = '{2'b10, 2'b10, 32'h03FF_FFFF, 32'h8000_0000, 32'h03FF_FFFF, 2'b01, 3};
    vecs[10] = '{2'b01, 2'b01, ham_enc(2'b01, 32'h5A5), 32'h0, 32'h5A5,     2'b00, 2};

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].c, vecs[i].w, vecs[i].d, vecs[i].nz, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_out);
      check($sformatf("v%0d_num_err", i), {30'h0, num_of_errors}, {30'h0, vecs[i].exp_err});
    end

    repeat (3) @(negedge clk);
    check("hold_data_out", data_out, 32'h5A5);
    check("hold_no_done", {31'h0, operation_done}, 32'h0);

    // Start during ENC is ignored; start during DONE is accepted.
    @(negedge clk);
    ctrl = 2'b00; codeword_width = 2'b00; data_in = 32'h5; start = 1'b1;
    @(negedge clk);
    check("b2b_busy", {31'h0, busy}, 32'h1);
    ctrl = 2'b01; data_in = 32'h3D;
    @(negedge clk);
    check("b2b_done1", {31'h0, operation_done}, 32'h1);
    check("b2b_data1", data_out, 32'h2D);
    check("b2b_latch", enc_data, 32'h5);
    ctrl = 2'b01; codeword_width = 2'b00; data_in = 32'h2E;
    @(negedge clk);
    start = 1'b0;
    check("b2b_mid_done", {31'h0, operation_done}, 32'h0);
    check("b2b_dec_data", dec_data, 32'h2E);
    @(negedge clk);
    check("b2b_done2", {31'h0, operation_done}, 32'h1);
    check("b2b_data2", data_out, 32'h5);
    check("b2b_err2", {30'h0, num_of_errors}, 32'h2);

    full_with_drops();
    illegal_start();

    // Reset while in DEC clears outputs at once and produces no done.
    @(negedge clk);
    ctrl = 2'b01; codeword_width = 2'b00; data_in = 32'h3D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_data_out", data_out, 32'h0);
    check("rst_mid_busy_clr", {31'h0, busy}, 32'h0);
    check("rst_mid_enc_data", enc_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (operation_done) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_mid_no_done", {31'h0, seen}, 32'h0);

`ifdef ECC_SEQ_STATS_EN
    for (int k = 0; k < 3; k++) run_op(2'b10, 2'b00, 32'h5, 32'h1, lat);
    check("stat_single_3", {16'h0, stat_single}, 32'd3);
    check("stat_ops_3", {16'h0, stat_ops}, 32'd3);
    check("stat_double_0", {16'h0, stat_double}, 32'd0);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("stat_single_clr", {16'h0, stat_single}, 32'd0);
    check("stat_ops_clr", {16'h0, stat_ops}, 32'd0);
    full_with_drops();
    check("stat_drop_2", {24'h0, stat_drop}, 32'd2);
    illegal_start();
    check("stat_drop_3", {24'h0, stat_drop}, 32'd3);
    check("stat_ops_1", {16'h0, stat_ops}, 32'd1);
    // Clear coinciding with an op completing wins over the increment.
    @(negedge clk);
    ctrl = 2'b00; codeword_width = 2'b00; data_in = 32'h5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("stat_clr_wins_done", {31'h0, operation_done}, 32'h1);
    check("stat_clr_wins_ops", {16'h0, stat_ops}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
